// File: rtl/ariane_pkg.sv
// Slice of the core package: branch-history-table update payload.
package ariane_pkg;

    localparam int unsigned VLEN = 64;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

endpackage

// File: rtl/bht_ckpt_ctrl_pkg.sv
// Shared constants and helpers for the BHT checkpoint controller.
package bht_ckpt_ctrl_pkg;

    localparam int unsigned BHT_CKPT_DEPTH_DEF = 4;
    localparam int unsigned BHT_CKPT_CNT_W_DEF = 8;

    // Idle value driven on the update bus when nothing is pending.
    function automatic ariane_pkg::bht_update_t bht_upd_idle();
        return '0;
    endfunction

endpackage

// File: rtl/bht_ckpt_ctrl_if.sv
// BHT update channel: the producer drives upd, the consumer samples it.
interface bht_ckpt_ctrl_if;

    ariane_pkg::bht_update_t upd;

    modport master (output upd);
    modport slave  (input  upd);

endinterface

// File: rtl/bht_upd_fifo.sv
// DEPTH-entry update FIFO; pointers carry one extra wrap bit to tell full from empty.
module bht_upd_fifo
    import bht_ckpt_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = BHT_CKPT_DEPTH_DEF,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    bht_ckpt_ctrl_if.slave        wr_if,
    bht_ckpt_ctrl_if.master       rd_if,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [PTR_W:0]        count_o
);

    ariane_pkg::bht_update_t mem_q [DEPTH];
    logic [PTR_W:0]          wr_ptr_q;
    logic [PTR_W:0]          rd_ptr_q;

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (count_o == (PTR_W + 1)'(DEPTH));
    assign empty_o   = (count_o == '0);
    assign rd_if.upd = empty_o ? bht_upd_idle() : mem_q[rd_ptr_q[PTR_W-1:0]];

    // Storage and pointer update; flush overrides push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_if.upd;
                wr_ptr_q                   <= wr_ptr_q + (PTR_W + 1)'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/bht_ckpt_ctrl.sv
// Switches the active BHT bank only after every buffered update has reached the old bank.
module bht_ckpt_ctrl
    import bht_ckpt_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = BHT_CKPT_DEPTH_DEF,
    parameter int unsigned CNT_W = BHT_CKPT_CNT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    debug_mode_i,
    input  logic                    mode_tgt_i,
    input  ariane_pkg::bht_update_t upd_i,
    output ariane_pkg::bht_update_t bht_update_o,
    output logic                    checkpoint_mode_o,
    output logic                    switched_o,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned INC_W = PTR_W + 2;
    localparam int unsigned SUM_W = CNT_W + INC_W;

    typedef enum logic [1:0] {
        NORMAL,
        CKPT,
        DRAIN_TO_CKPT,
        DRAIN_TO_NORMAL
    } state_e;

    state_e           state_q;
    logic             mode_q;
    logic             switched_q;
    logic             busy_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;
    logic [INC_W-1:0] drop_inc;
    logic [SUM_W-1:0] drop_sum;

    logic             steady;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W:0]   fifo_count;

    bht_ckpt_ctrl_if wr_if ();
    bht_ckpt_ctrl_if rd_if ();

    assign steady      = (state_q == NORMAL) || (state_q == CKPT);
    assign fifo_pop    = !fifo_empty;
    assign fifo_push   = upd_i.valid && steady && (!fifo_full || fifo_pop) && !flush_i;
    assign wr_if.upd   = upd_i;

    bht_upd_fifo #(
        .DEPTH (DEPTH)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wr_if   (wr_if),
        .rd_if   (rd_if),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A flushed head is counted as dropped, so it must not also be delivered.
    assign bht_update_o      = flush_i ? bht_upd_idle() : rd_if.upd;
    assign checkpoint_mode_o = mode_q;
    assign switched_o        = switched_q;
    assign busy_o            = busy_q;
    assign drop_cnt_o        = drop_cnt_q;

    // Discards this cycle: whole FIFO plus input on flush, else a refused input.
    always_comb begin
        drop_inc = '0;
        if (flush_i) begin
            drop_inc = INC_W'(fifo_count) + INC_W'(upd_i.valid);
        end else if (upd_i.valid && !fifo_push) begin
            drop_inc = INC_W'(1);
        end
        drop_sum   = SUM_W'(drop_cnt_q) + SUM_W'(drop_inc);
        drop_cnt_d = (drop_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(drop_sum);
    end

    // Saturating drop counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Mode FSM; the bank select only moves once the drain has emptied the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= NORMAL;
            mode_q     <= 1'b0;
            switched_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            switched_q <= 1'b0;
            unique case (state_q)
                NORMAL: begin
                    if (mode_tgt_i && !debug_mode_i) begin
                        state_q <= DRAIN_TO_CKPT;
                        busy_q  <= 1'b1;
                    end
                end
                CKPT: begin
                    if (!mode_tgt_i && !debug_mode_i) begin
                        state_q <= DRAIN_TO_NORMAL;
                        busy_q  <= 1'b1;
                    end
                end
                DRAIN_TO_CKPT: begin
                    if (fifo_empty) begin
                        state_q    <= CKPT;
                        mode_q     <= 1'b1;
                        switched_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                DRAIN_TO_NORMAL: begin
                    if (fifo_empty) begin
                        state_q    <= NORMAL;
                        mode_q     <= 1'b0;
                        switched_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bht_ckpt_ctrl.sv
// Self-checking bench for bht_ckpt_ctrl: vector table plus corner-case sequences.
module tb_bht_ckpt_ctrl;

    typedef struct {
        logic        flush;
        logic        dbg;
        logic        tgt;
        logic        vld;
        logic [15:0] pc;
        logic        acc;
        logic        e_vld;
        logic [15:0] e_pc;
        logic        e_mode;
        logic        e_sw;
        logic        e_busy;
        logic [7:0]  e_drop;
    } vec_t;

    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
        logic        mode;
    } sb_t;

    localparam int unsigned NVEC = 26;

    logic                    clk;
    logic                    rst_n;
    logic                    flush;
    logic                    dbg;
    logic                    tgt;
    ariane_pkg::bht_update_t out_upd;
    logic                    mode;
    logic                    sw;
    logic                    busy;
    logic [7:0]              drop;

    int   n_chk;
    int   n_pass;
    sb_t  exp_q [$];
    vec_t tbl [NVEC];

    bht_ckpt_ctrl_if u_if ();

    bht_ckpt_ctrl #(
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .flush_i           (flush),
        .debug_mode_i      (dbg),
        .mode_tgt_i        (tgt),
        .upd_i             (u_if.upd),
        .bht_update_o      (out_upd),
        .checkpoint_mode_o (mode),
        .switched_o        (sw),
        .busy_o            (busy),
        .drop_cnt_o        (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic f, input logic d, input logic t, input logic vl,
                               input logic [15:0] p, input logic a, input logic ev,
                               input logic [15:0] ep, input logic em, input logic es,
                               input logic eb, input logic [7:0] ed);
        vec_t r;
        r.flush = f;  r.dbg = d;     r.tgt = t;     r.vld = vl;
        r.pc = p;     r.acc = a;     r.e_vld = ev;  r.e_pc = ep;
        r.e_mode = em; r.e_sw = es;  r.e_busy = eb; r.e_drop = ed;
        return r;
    endfunction

    function automatic logic [95:0] tup(input logic vl, input logic [63:0] p, input logic tk,
                                        input logic m, input logic s, input logic b,
                                        input logic [7:0] dc);
        return 96'({vl, p, tk, m, s, b, dc});
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    task automatic drive(input logic f, input logic d, input logic t, input logic vl,
                         input logic [15:0] p);
        flush = f;
        dbg   = d;
        tgt   = t;
        u_if.upd.valid = vl;
        u_if.upd.pc    = vl ? 64'(p) : 64'd0;
        u_if.upd.taken = vl ? p[2] : 1'b0;
    endtask

    function automatic logic [95:0] act_tup();
        return tup(out_upd.valid, out_upd.pc, out_upd.taken, mode, sw, busy, drop);
    endfunction

    // Scoreboard: every delivered update must be the next expected one, in its bank.
    always @(negedge clk) begin
        if (rst_n && out_upd.valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 96'({out_upd.pc, out_upd.taken, mode}), 96'(0));
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                check("sb_order", 96'({out_upd.pc, out_upd.taken, mode}), 96'(e));
            end
        end
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        drive(0, 0, 0, 0, 16'h0);

        tbl[0]  = v(0,0,0,0,16'h000,0, 0,16'h000,0,0,0,0);
        tbl[1]  = v(0,0,0,1,16'h100,1, 1,16'h100,0,0,0,0);
        tbl[2]  = v(0,0,0,1,16'h104,1, 1,16'h104,0,0,0,0);
        tbl[3]  = v(0,0,0,1,16'h108,1, 1,16'h108,0,0,0,0);
        tbl[4]  = v(0,0,0,0,16'h000,0, 0,16'h000,0,0,0,0);
        tbl[5]  = v(0,0,0,1,16'h200,1, 1,16'h200,0,0,0,0);
        tbl[6]  = v(0,0,1,1,16'h204,1, 1,16'h204,0,0,1,0);
        tbl[7]  = v(0,0,1,0,16'h000,0, 0,16'h000,0,0,1,0);
        tbl[8]  = v(0,0,1,0,16'h000,0, 0,16'h000,1,1,0,0);
        tbl[9]  = v(0,0,1,0,16'h000,0, 0,16'h000,1,0,0,0);
        tbl[10] = v(0,0,0,1,16'h300,1, 1,16'h300,1,0,1,0);
        tbl[11] = v(0,0,0,1,16'h304,0, 0,16'h000,1,0,1,1);
        tbl[12] = v(0,0,0,1,16'h308,0, 0,16'h000,0,1,0,2);
        tbl[13] = v(0,0,1,0,16'h000,0, 0,16'h000,0,0,1,2);
        tbl[14] = v(0,0,1,1,16'h310,0, 0,16'h000,1,1,0,3);
        tbl[15] = v(0,0,0,0,16'h000,0, 0,16'h000,1,0,1,3);
        tbl[16] = v(0,0,0,1,16'h314,0, 0,16'h000,0,1,0,4);
        tbl[17] = v(0,1,1,0,16'h000,0, 0,16'h000,0,0,0,4);
        tbl[18] = v(0,1,1,1,16'h400,1, 1,16'h400,0,0,0,4);
        tbl[19] = v(0,1,1,0,16'h000,0, 0,16'h000,0,0,0,4);
        tbl[20] = v(0,0,1,0,16'h000,0, 0,16'h000,0,0,1,4);
        tbl[21] = v(0,0,1,0,16'h000,0, 0,16'h000,1,1,0,4);
        tbl[22] = v(0,0,1,0,16'h000,0, 0,16'h000,1,0,0,4);
        tbl[23] = v(0,1,0,0,16'h000,0, 0,16'h000,1,0,0,4);
        tbl[24] = v(0,1,0,1,16'h500,1, 1,16'h500,1,0,0,4);
        tbl[25] = v(0,1,0,0,16'h000,0, 0,16'h000,1,0,0,4);

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", act_tup(), tup(0, 64'd0, 0, 0, 0, 0, 8'd0));
        rst_n = 1'b1;

        // Each row: inputs for one cycle, outputs expected in the following cycle.
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(tbl[i].flush, tbl[i].dbg, tbl[i].tgt, tbl[i].vld, tbl[i].pc);
            if (tbl[i].acc) exp_q.push_back('{pc: 64'(tbl[i].pc), taken: tbl[i].pc[2],
                                                mode: tbl[i].e_mode});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), act_tup(),
                  tup(tbl[i].e_vld, 64'(tbl[i].e_pc), tbl[i].e_vld & tbl[i].e_pc[2],
                      tbl[i].e_mode, tbl[i].e_sw, tbl[i].e_busy, tbl[i].e_drop));
        end

        // Flush mid-drain: buffered entry and flush-cycle input are both dropped.
        drive(0, 0, 0, 1, 16'h600);
        @(posedge clk);
        #1;
        check("flush_pre", act_tup(), tup(1, 64'h600, 0, 1, 0, 1, 8'd4));
        drive(1, 0, 0, 1, 16'h604);
        @(posedge clk);
        #1;
        check("flush_empty", act_tup(), tup(0, 64'd0, 0, 1, 0, 1, 8'd6));
        drive(0, 0, 0, 0, 16'h0);
        @(posedge clk);
        #1;
        check("flush_switch", act_tup(), tup(0, 64'd0, 0, 0, 1, 0, 8'd6));

        // Reset while a drain is pending: entry vanishes, nothing delivered.
        drive(0, 0, 1, 1, 16'h700);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 16'h0);
        #1;
        check("rst_mid_drain", act_tup(), tup(0, 64'd0, 0, 0, 0, 0, 8'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_recover", act_tup(), tup(0, 64'd0, 0, 0, 0, 0, 8'd0));

        // Saturation: one drop per flushed cycle, 300 in total.
        drive(1, 0, 0, 1, 16'h800);
        repeat (254) @(posedge clk);
        #1;
        check("sat_254", act_tup(), tup(0, 64'd0, 0, 0, 0, 0, 8'd254));
        @(posedge clk);
        #1;
        check("sat_255", act_tup(), tup(0, 64'd0, 0, 0, 0, 0, 8'd255));
        repeat (45) @(posedge clk);
        #1;
        check("sat_hold", act_tup(), tup(0, 64'd0, 0, 0, 0, 0, 8'd255));
        drive(0, 0, 0, 0, 16'h0);
        repeat (2) @(posedge clk);
        #1;

        check("sb_drained", 96'(exp_q.size()), 96'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bht_ckpt_ctrl.md
BHT_CKPT_CTRL -- requirements
Module: bht_ckpt_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, update FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 8, width of the dropped-update counter.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discard all pending updates.
REQ-006 SHALL have port debug_mode_i  input  1  core in debug mode; freezes mode changes.
REQ-007 SHALL have port mode_tgt_i  input  1  requested predictor bank (0=A, 1=B), level-sensitive.
REQ-008 SHALL have port upd_i  input  bht_update_t  resolved-branch update from execute (valid, pc, taken).
REQ-009 SHALL have port bht_update_o  output  bht_update_t  update to the BHT bank mux.
REQ-010 SHALL have port checkpoint_mode_o  output  1  active bank select to the BHT bank mux.
REQ-011 SHALL have port switched_o  output  1  one-cycle pulse when checkpoint_mode_o changes.
REQ-012 SHALL have port busy_o  output  1  high in either DRAIN state.
REQ-013 SHALL have port drop_cnt_o  output  CNT_W  saturating count of discarded updates.

Function
REQ-014 SHALL buffer accepted updates in a DEPTH-entry FIFO and present the head on bht_update_o with valid=1 whenever non-empty; downstream always consumes, so the head pops every cycle it is valid.
REQ-015 SHALL give push-to-output latency of exactly 1 cycle: update accepted at edge t appears on bht_update_o in cycle t+1 if the FIFO was empty.
REQ-016 SHALL drive bht_update_o to all-zero when the FIFO is empty.
REQ-017 SHALL run FSM states NORMAL (mode 0), CKPT (mode 1), DRAIN_TO_CKPT, DRAIN_TO_NORMAL.
REQ-018 SHALL transition NORMAL->DRAIN_TO_CKPT when mode_tgt_i=1 and debug_mode_i=0; CKPT->DRAIN_TO_NORMAL when mode_tgt_i=0 and debug_mode_i=0.
REQ-019 SHALL stay in a DRAIN state until the FIFO is empty, then enter CKPT/NORMAL respectively, toggling checkpoint_mode_o and pulsing switched_o in the first cycle of the new state.
REQ-020 SHALL keep checkpoint_mode_o unchanged in DRAIN states, so every buffered update reaches the bank active when it was resolved.
REQ-021 SHALL complete the drain even if mode_tgt_i reverts mid-drain; the reverse request is then serviced from the new steady state.
REQ-022 SHALL accept upd_i.valid only in NORMAL/CKPT with the FIFO not full or popping that cycle; otherwise discard it and increment drop_cnt_o.
REQ-023 SHALL permit simultaneous push and pop, occupancy unchanged; push to empty FIFO does not bypass (latency per REQ-015).
REQ-024 SHALL, on flush_i, empty the FIFO next cycle, add the number of discarded valid entries plus any valid upd_i that cycle to drop_cnt_o, and in a DRAIN state complete the switch in the following cycle.
REQ-025 SHALL saturate drop_cnt_o at 2^CNT_W-1, never wrapping.
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH using an extra occupancy bit to distinguish full from empty.

Reset
REQ-027 SHALL on rst_ni low: state NORMAL, FIFO empty, bht_update_o zero, checkpoint_mode_o 0, switched_o 0, busy_o 0, drop_cnt_o 0.
REQ-028 SHALL, on reset mid-drain, abandon the drain and discard pending updates without counting them.

Structure
REQ-029 SHALL take bht_update_t from ariane_pkg; the FSM state enum is local to the module.
REQ-030 SHALL implement the buffer as one sub-module, bht_upd_fifo (DEPTH, push/pop/flush/full/empty/count).

Verification
REQ-031 SHALL cover: three back-to-back updates pc=0x100,0x104,0x108 in NORMAL -> emitted cycles t+1..t+3 in order, checkpoint_mode_o=0.
REQ-032 SHALL cover: 2 updates buffered, mode_tgt_i 0->1 -> busy_o=1 two cycles, both emitted with mode 0, then checkpoint_mode_o=1, switched_o single pulse.
REQ-033 SHALL cover: valid upd_i every cycle during a 4-cycle drain -> 4 drops, drop_cnt_o=4, none emitted.
REQ-034 SHALL cover: flush_i with 3 buffered in DRAIN_TO_NORMAL -> FIFO empty next cycle, drop_cnt_o+=3, mode 0 the cycle after.
REQ-035 SHALL cover: mode_tgt_i=1 while debug_mode_i=1 -> state stays NORMAL; deassert debug -> switch proceeds.
REQ-036 SHALL cover: 300 drops with CNT_W=8 -> drop_cnt_o holds 255.
